// File: rtl/display_sequencer.sv
// Steps a small RAM address through FETCH/CAPTURE/HOLD and shows address and data on hex digits.
// Optional macro DISPLAY_SEQUENCER_DIR_EN adds a dir input that selects down-counting addresses.
module display_sequencer #(
  parameter int TICK_CYCLES = 50000000,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              step,
`ifdef DISPLAY_SEQUENCER_DIR_EN
  input  logic              dir,
`endif
  input  logic [3:0]        rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        addr_hi,
  output logic [3:0]        addr_lo,
  output logic [3:0]        data_nib,
  output logic              valid
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {FETCH, CAPTURE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tick_cnt, tick_cnt_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [3:0]        data_nib_nxt;
  logic              valid_nxt;
  logic              advance;
  logic              count_down;

`ifdef DISPLAY_SEQUENCER_DIR_EN
  assign count_down = dir;
`else
  assign count_down = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic down);
    return down ? a - ADDR_W'(1) : a + ADDR_W'(1);
  endfunction

  // Pause beats the terminal count; while paused only step can advance.
  assign advance = (state == HOLD) && (pause ? step : (tick_cnt == TICK_LAST));

  assign addr_hi = 4'(rd_addr[ADDR_W-1:4]);
  assign addr_lo = rd_addr[3:0];

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (advance) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    rd_addr_nxt  = rd_addr;
    data_nib_nxt = data_nib;
    valid_nxt    = valid;
    tick_cnt_nxt = tick_cnt;
    case (state)
      CAPTURE: begin
        data_nib_nxt = rd_data;
        valid_nxt    = 1'b1;
        tick_cnt_nxt = '0;
      end
      HOLD: begin
        if (advance) begin
          rd_addr_nxt  = next_addr(rd_addr, count_down);
          valid_nxt    = 1'b0;
          tick_cnt_nxt = '0;
        end else if (pause) begin
          tick_cnt_nxt = '0;
        end else begin
          tick_cnt_nxt = tick_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr  <= '0;
      data_nib <= '0;
      valid    <= 1'b0;
      tick_cnt <= '0;
    end else begin
      rd_addr  <= rd_addr_nxt;
      data_nib <= data_nib_nxt;
      valid    <= valid_nxt;
      tick_cnt <= tick_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer with TICK_CYCLES=4, ADDR_W=5 and a 1-cycle RAM (mem[a]=a[3:0]^A).
module tb_display_sequencer;
  localparam int TICK = 4;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          reset, pause, step;
  logic [3:0]    rd_data = 4'h0;
  logic [AW-1:0] rd_addr;
  logic [3:0]    addr_hi, addr_lo, data_nib;
  logic          valid;
`ifdef DISPLAY_SEQUENCER_DIR_EN
  logic          dir;
`endif

  int vectors = 0;
  int miscompares = 0;

  display_sequencer #(.TICK_CYCLES(TICK), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .pause(pause), .step(step),
`ifdef DISPLAY_SEQUENCER_DIR_EN
    .dir(dir),
`endif
    .rd_data(rd_data), .rd_addr(rd_addr), .addr_hi(addr_hi), .addr_lo(addr_lo),
    .data_nib(data_nib), .valid(valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_addr[3:0] ^ 4'hA;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From HOLD with tick_cnt=0: three counting edges, then the advance edge.
  task automatic run_to_fetch(input logic [4:0] cur, input logic [4:0] nxt);
    tick(3);
    vectors++;
    if (rd_addr !== cur || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_addr: got addr=%0d valid=%b, expected addr=%0d valid=1", rd_addr, valid, cur);
    end
    tick();
    vectors++;
    if (rd_addr !== nxt || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL advance: got addr=%0d valid=%b, expected addr=%0d valid=0", rd_addr, valid, nxt);
    end
    vectors++;
    if (addr_hi !== {3'b000, nxt[4]} || addr_lo !== nxt[3:0]) begin
      miscompares++;
      $display("FAIL addr_digits: got hi=%h lo=%h, expected hi=%h lo=%h", addr_hi, addr_lo, {3'b000, nxt[4]}, nxt[3:0]);
    end
    vectors++;
    if (data_nib !== (cur[3:0] ^ 4'hA)) begin
      miscompares++;
      $display("FAIL data_held: got %h expected %h", data_nib, cur[3:0] ^ 4'hA);
    end
  endtask

  // From FETCH: valid stays low through CAPTURE, rises after the capture edge.
  task automatic finish_capture(input logic [4:0] a);
    tick();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_valid: got %b expected 0", valid);
    end
    tick();
    vectors++;
    if (valid !== 1'b1 || data_nib !== (a[3:0] ^ 4'hA) || rd_addr !== a) begin
      miscompares++;
      $display("FAIL captured: got valid=%b data=%h addr=%0d, expected valid=1 data=%h addr=%0d", valid, data_nib, rd_addr, a[3:0] ^ 4'hA, a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pause = 1'b0; step = 1'b0;
    tick(2);
    vectors++;
    if (rd_addr !== 5'd0 || valid !== 1'b0 || data_nib !== 4'h0 || addr_hi !== 4'h0 || addr_lo !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: got addr=%0d valid=%b data=%h hi=%h lo=%h, expected all 0", rd_addr, valid, data_nib, addr_hi, addr_lo);
    end
    reset = 1'b0;
    finish_capture(5'd0);
  endtask

  task automatic test_free_run();
    for (int n = 0; n < 3; n++) begin
      run_to_fetch(5'(n), 5'(n + 1));
      finish_capture(5'(n + 1));
    end
  endtask

  task automatic test_pause_step();
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (rd_addr !== 5'd3 || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL paused_hold: got addr=%0d valid=%b, expected addr=3 valid=1", rd_addr, valid);
      end
    end
    step = 1'b1; tick(); step = 1'b0;
    vectors++;
    if (rd_addr !== 5'd4 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL step_advance: got addr=%0d valid=%b, expected addr=4 valid=0", rd_addr, valid);
    end
    step = 1'b1; tick(); step = 1'b0;
    vectors++;
    if (rd_addr !== 5'd4) begin
      miscompares++;
      $display("FAIL step_in_fetch: got addr=%0d expected 4", rd_addr);
    end
    tick();
    vectors++;
    if (valid !== 1'b1 || data_nib !== 4'hE) begin
      miscompares++;
      $display("FAIL capture_after_step: got valid=%b data=%h, expected valid=1 data=e", valid, data_nib);
    end
    tick(5);
    vectors++;
    if (rd_addr !== 5'd4) begin
      miscompares++;
      $display("FAIL step_not_queued: got addr=%0d expected 4", rd_addr);
    end
  endtask

  task automatic test_pause_at_terminal();
    pause = 1'b0;
    tick(3);
    pause = 1'b1;
    tick();
    vectors++;
    if (rd_addr !== 5'd4 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_wins: got addr=%0d valid=%b, expected addr=4 valid=1", rd_addr, valid);
    end
    pause = 1'b0;
    tick(3);
    vectors++;
    if (rd_addr !== 5'd4) begin
      miscompares++;
      $display("FAIL full_dwell_early: got addr=%0d expected 4", rd_addr);
    end
    tick();
    vectors++;
    if (rd_addr !== 5'd5 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_dwell_advance: got addr=%0d valid=%b, expected addr=5 valid=0", rd_addr, valid);
    end
    finish_capture(5'd5);
  endtask

  task automatic test_reset_in_fetch();
    for (int n = 5; n < 8; n++) begin
      run_to_fetch(5'(n), 5'(n + 1));
      finish_capture(5'(n + 1));
    end
    run_to_fetch(5'd8, 5'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (rd_addr !== 5'd0 || valid !== 1'b0 || data_nib !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: got addr=%0d valid=%b data=%h, expected addr=0 valid=0 data=0", rd_addr, valid, data_nib);
    end
    finish_capture(5'd0);
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 31; n++) begin
      run_to_fetch(5'(n), 5'(n + 1));
      finish_capture(5'(n + 1));
    end
    vectors++;
    if (addr_hi !== 4'h1 || addr_lo !== 4'hF) begin
      miscompares++;
      $display("FAIL top_digits: got hi=%h lo=%h, expected hi=1 lo=f", addr_hi, addr_lo);
    end
    run_to_fetch(5'd31, 5'd0);
    finish_capture(5'd0);
  endtask

`ifdef DISPLAY_SEQUENCER_DIR_EN
  task automatic test_dir_down();
    dir = 1'b1;
    run_to_fetch(5'd0, 5'd31);
    finish_capture(5'd31);
    run_to_fetch(5'd31, 5'd30);
    finish_capture(5'd30);
    dir = 1'b0;
  endtask
`endif

  initial begin
`ifdef DISPLAY_SEQUENCER_DIR_EN
    dir = 1'b0;
`endif
    test_reset();
    test_free_run();
    test_pause_step();
    test_pause_at_terminal();
    test_reset_in_fetch();
    test_wrap();
`ifdef DISPLAY_SEQUENCER_DIR_EN
    test_dir_down();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
